// File: rtl/nfca_tx_framer.sv
// NFC-A (ISO 14443-3 Type A) PCD transmit framer: buffers one frame, classifies it and
// serialises S bit, LSB-first data with odd parity, optional CRC_A and E bit, one bit per tx_req.
module nfca_tx_framer #(
  parameter int          BUF_AW   = 12,
  parameter logic [15:0] CRC_INIT = 16'h6363
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_tvalid,
  output logic       tx_tready,
  input  logic [7:0] tx_tdata,
  input  logic [3:0] tx_tdatab,
  input  logic       tx_tlast,
  input  logic [1:0] tx_crc_mode,
  input  logic       tx_abort,
  input  logic       tx_req,
  output logic       tx_en,
  output logic       tx_bit,
  output logic [2:0] remainb,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       err_ovf
);

  typedef enum logic [2:0] {IDLE, SOF, FETCH, DATA, CRC, EOF, FINISH} state_t;

  localparam logic [BUF_AW-1:0] PTR_MAX = '1;

  state_t            state_q;
  logic              tready_q, txEn_q, txBit_q, busy_q, done_q, ovf_q;
  logic [2:0]        remainb_q;
  logic [BUF_AW-1:0] wrPtr_q, rdPtr_q, len_q;
  logic [3:0]        lastb_q, nBits_q;
  logic [1:0]        mode_q;
  logic [15:0]       crc_q;
  logic              crcEn_q, sel_q, fetchWait_q, parEn_q, lastByte_q;
  logic [7:0]        shReg_q, byte_q, rdData_q;
  logic [4:0]        bitCnt_q;
  logic [17:0]       crcSh_q;
  logic [7:0]        mem [2**BUF_AW];

  logic        accept_d, isShort_d, isSel_d, isLast_d, partial_d, byteEnd_d;
  logic [3:0]  lastbIn_d;
  logic [15:0] crcNext_d;

  function automatic logic [15:0] crcUpdate(input logic [15:0] crcIn, input logic [7:0] data);
    logic [15:0] c;
    c = crcIn ^ {8'h00, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    return c;
  endfunction

  assign accept_d  = tx_tvalid && tready_q && (state_q == IDLE) && !tx_abort;
  assign crcNext_d = crcUpdate(crc_q, tx_tdata);
  assign isShort_d = (rdData_q == 8'h26) || (rdData_q == 8'h52) || (rdData_q == 8'h35) ||
                     (rdData_q[7:4] == 4'h4) || (rdData_q[7:3] == 5'h0F);
  assign isSel_d   = (rdData_q == 8'h93) || (rdData_q == 8'h95) || (rdData_q == 8'h97);
  assign isLast_d  = (rdPtr_q == len_q - BUF_AW'(1));
  assign partial_d = isLast_d && (lastb_q != 4'd8);
  // A byte ends after its parity bit, or after its last data bit when parity is off.
  assign byteEnd_d = (bitCnt_q == {1'b0, nBits_q}) ||
                     (!parEn_q && (bitCnt_q + 5'd1 == {1'b0, nBits_q}));

  always_comb begin
    lastbIn_d = tx_tdatab;
    if (tx_tdatab == 4'd0)     lastbIn_d = 4'd1;
    else if (tx_tdatab > 4'd8) lastbIn_d = 4'd8;
  end

  always_ff @(posedge clk) begin
    if (accept_d) mem[wrPtr_q] <= tx_tdata;
    rdData_q <= mem[rdPtr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;   tready_q <= 1'b0; txEn_q <= 1'b0; txBit_q <= 1'b0;
      busy_q <= 1'b0;    done_q <= 1'b0;   ovf_q <= 1'b0;  remainb_q <= 3'd0;
      wrPtr_q <= '0;     rdPtr_q <= '0;    len_q <= '0;    lastb_q <= 4'd8;
      mode_q <= 2'd0;    crc_q <= CRC_INIT; crcEn_q <= 1'b0; sel_q <= 1'b0;
      fetchWait_q <= 1'b0; parEn_q <= 1'b0; lastByte_q <= 1'b0; nBits_q <= 4'd8;
      shReg_q <= 8'h00;  byte_q <= 8'h00;  bitCnt_q <= 5'd0; crcSh_q <= '0;
    end else begin
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      if (state_q != IDLE && tx_abort) begin
        state_q <= IDLE; txEn_q <= 1'b0; txBit_q <= 1'b0; busy_q <= 1'b0;
        tready_q <= 1'b1; wrPtr_q <= '0; rdPtr_q <= '0; crc_q <= CRC_INIT;
      end else begin
        case (state_q)
          IDLE: begin
            tready_q <= 1'b1;
            if (tx_abort) begin
              wrPtr_q <= '0;
              crc_q   <= CRC_INIT;
            end else if (accept_d) begin
              if (tx_tlast && wrPtr_q == PTR_MAX) begin
                ovf_q   <= 1'b1;
                wrPtr_q <= '0;
                crc_q   <= CRC_INIT;
              end else if (tx_tlast) begin
                crc_q    <= crcNext_d;
                len_q    <= wrPtr_q + BUF_AW'(1);
                lastb_q  <= lastbIn_d;
                mode_q   <= tx_crc_mode;
                rdPtr_q  <= '0;
                tready_q <= 1'b0;
                busy_q   <= 1'b1;
                state_q  <= SOF;
              end else begin
                crc_q <= crcNext_d;
                if (wrPtr_q != PTR_MAX) wrPtr_q <= wrPtr_q + BUF_AW'(1);
              end
            end
          end
          SOF: if (tx_req) begin
            txEn_q <= 1'b1; txBit_q <= 1'b0; fetchWait_q <= 1'b1; state_q <= FETCH;
          end
          FETCH: begin
            // rdData_q is valid on the second FETCH cycle after rdPtr_q settles.
            if (fetchWait_q) fetchWait_q <= 1'b0;
            else begin
              shReg_q <= rdData_q; byte_q <= rdData_q; bitCnt_q <= 5'd0; state_q <= DATA;
              if (partial_d) begin
                nBits_q <= lastb_q; parEn_q <= 1'b0; lastByte_q <= 1'b1;
              end else if (rdPtr_q == '0 && mode_q == 2'd0 && isShort_d) begin
                nBits_q <= 4'd7; parEn_q <= 1'b0; lastByte_q <= 1'b1;
              end else begin
                nBits_q <= 4'd8; parEn_q <= (mode_q != 2'd3); lastByte_q <= isLast_d;
              end
              if (rdPtr_q == '0) begin
                crcEn_q <= (mode_q == 2'd1) || (mode_q == 2'd0 && !isShort_d && !isSel_d);
                sel_q   <= (mode_q == 2'd0) && isSel_d;
              end else if (rdPtr_q == BUF_AW'(1) && sel_q) begin
                crcEn_q <= (rdData_q == 8'h70);
              end
            end
          end
          DATA: if (tx_req) begin
            if (bitCnt_q < {1'b0, nBits_q}) begin
              txBit_q <= shReg_q[0];
              shReg_q <= shReg_q >> 1;
            end else begin
              txBit_q <= ~^byte_q;
            end
            bitCnt_q <= bitCnt_q + 5'd1;
            if (byteEnd_d) begin
              bitCnt_q <= 5'd0;
              if (!lastByte_q) begin
                rdPtr_q <= rdPtr_q + BUF_AW'(1); fetchWait_q <= 1'b1; state_q <= FETCH;
              end else if (crcEn_q && lastb_q == 4'd8) begin
                crcSh_q <= {~^crc_q[15:8], crc_q[15:8], ~^crc_q[7:0], crc_q[7:0]};
                state_q <= CRC;
              end else begin
                state_q <= EOF;
              end
            end
          end
          CRC: if (tx_req) begin
            txBit_q  <= crcSh_q[0];
            crcSh_q  <= crcSh_q >> 1;
            bitCnt_q <= bitCnt_q + 5'd1;
            if (bitCnt_q == 5'd17) state_q <= EOF;
          end
          EOF: if (tx_req) begin
            txBit_q   <= 1'b0;
            remainb_q <= (lastb_q == 4'd8) ? 3'd0 : lastb_q[2:0];
            state_q   <= FINISH;
          end
          FINISH: if (tx_req) begin
            txEn_q <= 1'b0; txBit_q <= 1'b0; done_q <= 1'b1; busy_q <= 1'b0;
            wrPtr_q <= '0; rdPtr_q <= '0; crc_q <= CRC_INIT; tready_q <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign tx_tready = tready_q;
  assign tx_en     = txEn_q;
  assign tx_bit    = txBit_q;
  assign remainb   = remainb_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;
  assign err_ovf   = ovf_q;

endmodule

// File: tb/tb_nfca_tx_framer.sv
// Directed bench for nfca_tx_framer (BUF_AW=4): REQA, HLTA, anticollision, overflow,
// abort and reset-mid-frame, with hand-derived expected bit streams.
module tb_nfca_tx_framer;

  logic       clk = 1'b0;
  logic       rst, tx_tvalid, tx_tlast, tx_abort, tx_req;
  logic [7:0] tx_tdata;
  logic [3:0] tx_tdatab;
  logic [1:0] tx_crc_mode;
  logic       tx_tready, tx_en, tx_bit, tx_busy, tx_done, err_ovf;
  logic [2:0] remainb;

  int         assertCount = 0;
  int         failCount   = 0;
  logic [7:0] frameBytes [0:31];
  logic       expQ [$];

  always #5 clk = ~clk;

  nfca_tx_framer #(.BUF_AW(4), .CRC_INIT(16'h6363)) dut (
    .clk(clk), .rst(rst), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
    .tx_tdata(tx_tdata), .tx_tdatab(tx_tdatab), .tx_tlast(tx_tlast),
    .tx_crc_mode(tx_crc_mode), .tx_abort(tx_abort), .tx_req(tx_req),
    .tx_en(tx_en), .tx_bit(tx_bit), .remainb(remainb), .tx_busy(tx_busy),
    .tx_done(tx_done), .err_ovf(err_ovf)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Streams frameBytes[0..n-1]; afterwards checks either acceptance or an overflow drop.
  task automatic applyStimulus(input int n, input logic [3:0] datab, input logic [1:0] mode,
                               input bit expectAccept);
    int w;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx_tvalid = 1'b1; tx_tdata = frameBytes[i]; tx_tlast = (i == n - 1);
      tx_tdatab = datab; tx_crc_mode = mode;
      w = 0;
      while (!tx_tready && w < 20) begin @(negedge clk); w++; end
      if (w == 20) checkOutput("tready_wait", {31'd0, tx_tready}, 32'd1);
    end
    @(negedge clk);
    tx_tvalid = 1'b0; tx_tlast = 1'b0;
    if (expectAccept) begin
      checkOutput("accept_busy", tx_busy, 1);
      checkOutput("accept_tready", tx_tready, 0);
    end else begin
      checkOutput("ovf_pulse", err_ovf, 1);
      checkOutput("ovf_tready", tx_tready, 1);
      checkOutput("ovf_busy", tx_busy, 0);
    end
  endtask

  task automatic pulseReq(input logic abort, output logic en, output logic bitv, output logic done);
    @(negedge clk);
    tx_req = 1'b1; tx_abort = abort;
    @(negedge clk);
    tx_req = 1'b0; tx_abort = 1'b0;
    en = tx_en; bitv = tx_bit; done = tx_done;
    repeat (3) @(negedge clk);
  endtask

  task automatic addByte(input logic [7:0] b, input int nbits, input bit par);
    for (int i = 0; i < nbits; i++) expQ.push_back(b[i]);
    if (par) expQ.push_back(~^b);
  endtask

  task automatic checkFrame(input string name, input logic [2:0] expRemain);
    logic en, b, d;
    for (int k = 0; k < expQ.size(); k++) begin
      pulseReq(1'b0, en, b, d);
      checkOutput($sformatf("%s_en_done%0d", name, k), {en, d}, 2'b10);
      checkOutput($sformatf("%s_bit%0d", name, k), b, expQ[k]);
    end
    pulseReq(1'b0, en, b, d);
    checkOutput({name, "_done"}, d, 1);
    checkOutput({name, "_en_off"}, en, 0);
    checkOutput({name, "_busy_off"}, tx_busy, 0);
    checkOutput({name, "_tready"}, tx_tready, 1);
    checkOutput({name, "_remainb"}, remainb, expRemain);
    expQ.delete();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_tready"}, tx_tready, 0);
    checkOutput({tag, "_en"}, tx_en, 0);
    checkOutput({tag, "_bit"}, tx_bit, 0);
    checkOutput({tag, "_remainb"}, remainb, 0);
    checkOutput({tag, "_busy"}, tx_busy, 0);
    checkOutput({tag, "_done"}, tx_done, 0);
    checkOutput({tag, "_ovf"}, err_ovf, 0);
  endtask

  task automatic loadReqa();
    frameBytes[0] = 8'h26;
    applyStimulus(1, 4'd8, 2'd0, 1'b1);
    expQ = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  endtask

  task automatic loadHlta();
    frameBytes[0] = 8'h50; frameBytes[1] = 8'h00;
    applyStimulus(2, 4'd8, 2'd0, 1'b1);
  endtask

  initial begin
    logic en, b, d, sawDone;
    rst = 1'b1; tx_tvalid = 1'b0; tx_tlast = 1'b0; tx_abort = 1'b0; tx_req = 1'b0;
    tx_tdata = 8'h00; tx_tdatab = 4'd8; tx_crc_mode = 2'd0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b0;
    @(negedge clk);
    checkOutput("tready_after_reset", tx_tready, 1);

    $display("[TB] REQA short frame");
    loadReqa();
    checkFrame("reqa", 3'd0);

    $display("[TB] HLTA with CRC 57 CD");
    loadHlta();
    expQ.push_back(1'b0);
    addByte(8'h50, 8, 1); addByte(8'h00, 8, 1); addByte(8'h57, 8, 1); addByte(8'hCD, 8, 1);
    expQ.push_back(1'b0);
    checkFrame("hlta", 3'd0);

    $display("[TB] overflow then 15-byte mode-2 frame");
    for (int i = 0; i < 16; i++) frameBytes[i] = 8'(i * 13 + 5);
    applyStimulus(16, 4'd8, 2'd0, 1'b0);
    pulseReq(1'b0, en, b, d);
    checkOutput("ovf_no_tx", {en, d}, 2'b00);
    for (int i = 0; i < 15; i++) frameBytes[i] = 8'(i * 17);
    applyStimulus(15, 4'd8, 2'd2, 1'b1);
    expQ.push_back(1'b0);
    for (int i = 0; i < 15; i++) addByte(8'(i * 17), 8, 1);
    expQ.push_back(1'b0);
    checkOutput("len15_bits", expQ.size(), 137);
    checkFrame("len15", 3'd0);

    $display("[TB] bit-oriented anticollision");
    frameBytes[0] = 8'h93; frameBytes[1] = 8'h25; frameBytes[2] = 8'h0A;
    applyStimulus(3, 4'd5, 2'd0, 1'b1);
    expQ.push_back(1'b0);
    addByte(8'h93, 8, 1); addByte(8'h25, 8, 1); addByte(8'h0A, 5, 0);
    expQ.push_back(1'b0);
    checkFrame("anticoll", 3'd5);

    $display("[TB] abort during HLTA");
    loadHlta();
    for (int k = 0; k < 4; k++) pulseReq(1'b0, en, b, d);
    checkOutput("abort_pre_en", en, 1);
    pulseReq(1'b1, en, b, d);
    checkOutput("abort_en_bit", {en, b}, 2'b00);
    checkOutput("abort_tready", tx_tready, 1);
    checkOutput("abort_busy", tx_busy, 0);
    checkOutput("abort_remainb", remainb, 5);
    sawDone = d;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      sawDone = sawDone | tx_done;
    end
    checkOutput("abort_no_done", sawDone, 0);

    $display("[TB] reset during CRC phase");
    loadHlta();
    for (int k = 0; k < 22; k++) pulseReq(1'b0, en, b, d);
    checkOutput("crc_phase_en", en, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkResetValues("midreset");
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_tready", tx_tready, 1);

    $display("[TB] idle abort discards partial frame, then REQA");
    tx_tvalid = 1'b1; tx_tdata = 8'h93; tx_tlast = 1'b0;
    @(negedge clk);
    tx_tvalid = 1'b0; tx_abort = 1'b1;
    @(negedge clk);
    tx_abort = 1'b0;
    loadReqa();
    checkFrame("reqa2", 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
